branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Multi-cycle conditional-branch executor for the CPU datapath's control path. It accepts a branch instruction from the control unit, fetches register Ra over a request/acknowledge handshake, and evaluates the C2 condition (zero / nonzero / positive / negative) on the fetched value. On a taken branch it drives the target PC and a one-cycle PC load strobe. It is the producer of branch decisions that the datapath PC logic consumes.

## Interface
- BR_OPCODE, 5'b10010, opcode value (ir[31:27]) accepted as a conditional branch
- clk  input  1  system clock, all state changes on rising edge
- clr  input  1  synchronous active-high reset
- start  input  1  request to execute the instruction on ir; sampled only in IDLE
- ir  input  32  instruction word; opcode [31:27], Ra [26:23], C2 [20:19], C [18:0] signed
- pc_in  input  32  already-incremented PC (PC+1) of the branch instruction
- rd_req  output  1  register read request, held until rd_ack
- ra_sel  output  4  register index for the read, valid while rd_req=1
- rd_ack  input  1  read complete; reg_data valid this cycle
- reg_data  input  32  value of Ra
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on completion of a valid branch
- err  output  1  one-cycle pulse when start is accepted with opcode != BR_OPCODE
- taken  output  1  condition result, held from COMMIT until the next accepted start
- pc_load  output  1  one-cycle strobe: load pc_next into PC
- pc_next  output  32  branch target, pc_in + sign_extend(C)
- taken_cnt  output  16  taken-branch counter (see Configuration)
- nottaken_cnt  output  16  not-taken-branch counter (see Configuration)

## Operation
- States: IDLE, READ, EVAL, COMMIT.
- IDLE: on start=1, latch ir fields and pc_in.
  - If opcode matches BR_OPCODE, go to READ.
  - Otherwise pulse err the next cycle and stay in IDLE; no read, no pc_load.
- READ: rd_req=1 and ra_sel=latched Ra. On rd_ack=1, latch reg_data and go to EVAL. Wait indefinitely without rd_ack.
- EVAL: compute the flag from the latched value v and C2:
  - 00: v==0
  - 01: v!=0
  - 10: v[31]==0 (zero counts as positive)
  - 11: v[31]==1
  - Compute target = latched pc_in + {{13{C[18]}},C}, 32-bit modulo (wraps, no overflow flag). Go to COMMIT.
- COMMIT:
  - taken=flag.
  - pc_load=flag.
  - pc_next=target, regardless of flag.
  - done=1.
  - Return to IDLE.
- start is ignored while busy=1. ir and pc_in are not sampled outside IDLE.
- rd_ack outside READ is ignored.

## Timing
- Reset values: state IDLE, rd_req 0, ra_sel 0, busy 0, done 0, err 0, taken 0, pc_load 0, pc_next 0, taken_cnt 0, nottaken_cnt 0.
- clr mid-operation: returns to IDLE on the next edge. An outstanding rd_req drops immediately and the pending ack is discarded. No done or pc_load is issued.
- Latency with rd_ack in the first READ cycle: start at edge N, READ during N+1, EVAL N+2, COMMIT (done/pc_load high) N+3, IDLE N+4. Each extra wait cycle before rd_ack adds one cycle.
- err is high during cycle N+1; a new start is accepted in that same cycle.
- Back-to-back: a start presented in the COMMIT cycle is ignored. The earliest next acceptance is the first IDLE cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- BRANCH_STATS_EN defined:
  - taken_cnt increments in each COMMIT with flag=1; nottaken_cnt increments in each COMMIT with flag=0.
  - Both counters are 16-bit, saturate at 16'hFFFF, and clear on clr.
- BRANCH_STATS_EN undefined: both ports remain but are constant 0; no counter registers are synthesized.

## Test plan
- brzr, Ra=5, reg_data=0, C=19'h00010, pc_in=32'h100, rd_ack immediate -> done and pc_load at N+3, taken=1, pc_next=32'h110.
- brnz, reg_data=0, C=19'h7FFFC (−4), pc_in=32'h100 -> pc_load=0, taken=0, pc_next=32'hFC, done=1.
- brpl/brmi, reg_data=32'h80000000 -> brpl taken=0, brmi taken=1; reg_data=0 with brpl -> taken=1.
- rd_ack delayed 3 cycles, with start pulses during busy -> done at N+6, extra starts ignored, ra_sel stable while rd_req=1.
- Opcode 5'b00011 with start -> err pulse at N+1, rd_req never asserted; then clr asserted during READ of a valid branch -> IDLE next edge, no done/pc_load.
- With BRANCH_STATS_EN: 3 taken and 2 not-taken branches -> taken_cnt=3, nottaken_cnt=2. Force taken_cnt to 16'hFFFF, run one more taken branch -> stays 16'hFFFF.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// ============================================================================
//  Module      : branch_sequencer_if
//  Description : Command, register-read and result signals between the
//                branch sequencer and its environment (control unit, register
//                file, PC logic). 'slave' is the sequencer's view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_sequencer_if;
    // command from the control unit
    logic        start;
    logic [31:0] ir;
    logic [31:0] pc_in;
    // register-file read port
    logic        rd_req;
    logic [3:0]  ra_sel;
    logic        rd_ack;
    logic [31:0] reg_data;
    // status and branch result
    logic        busy;
    logic        done;
    logic        err;
    logic        taken;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [15:0] taken_cnt;
    logic [15:0] nottaken_cnt;

    modport slave (
        input  start, ir, pc_in, rd_ack, reg_data,
        output rd_req, ra_sel, busy, done, err, taken, pc_load, pc_next,
               taken_cnt, nottaken_cnt
    );

    modport master (
        output start, ir, pc_in, rd_ack, reg_data,
        input  rd_req, ra_sel, busy, done, err, taken, pc_load, pc_next,
               taken_cnt, nottaken_cnt
    );
endinterface

`default_nettype wire

// File: rtl/branch_sequencer.sv
// ============================================================================
//  Module      : branch_sequencer
//  Description : Multi-cycle conditional-branch executor: fetches Ra over a
//                req/ack handshake, evaluates C2 and drives the branch target
//                with a one-cycle PC load strobe. Optional branch statistics
//                counters are built when BRANCH_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_sequencer #(
    parameter logic [4:0] BR_OPCODE = 5'b10010
) (
    input  logic              clk,
    input  logic              clr,
    branch_sequencer_if.slave bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_READ   = 2'd1;
    localparam logic [1:0] c_EVAL   = 2'd2;
    localparam logic [1:0] c_COMMIT = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    // latched instruction fields and operand
    logic [1:0]  r_c2;
    logic [18:0] r_c;
    logic [31:0] r_pc;
    logic [31:0] r_value;
    logic [3:0]  r_ra_sel;

    // registered outputs and their next values
    logic        r_busy,    w_busy_nxt;
    logic        r_rd_req,  w_rd_req_nxt;
    logic        r_done,    w_done_nxt;
    logic        r_err,     w_err_nxt;
    logic        r_taken,   w_taken_nxt;
    logic        r_pc_load, w_pc_load_nxt;
    logic [31:0] r_pc_next, w_pc_next_nxt;

    logic        w_op_ok;
    logic        w_accept;
    logic        w_flag;
    logic [31:0] w_target;
    logic        w_unused_ir;

    assign w_op_ok     = (bus.ir[31:27] == BR_OPCODE);
    assign w_accept    = (r_state == c_IDLE) && bus.start;
    assign w_unused_ir = &{1'b0, bus.ir[22:21]};

    // ------------------------------------------------------------------
    // state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (bus.start && w_op_ok) w_state_nxt = c_READ;
            c_READ:   if (bus.rd_ack)           w_state_nxt = c_EVAL;
            c_EVAL:                             w_state_nxt = c_COMMIT;
            c_COMMIT:                           w_state_nxt = c_IDLE;
            default:                            w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // condition evaluation and target arithmetic on latched operands
    // ------------------------------------------------------------------
    always_comb begin
        w_flag = 1'b0;
        case (r_c2)
            2'b00: w_flag = (r_value == 32'd0);
            2'b01: w_flag = (r_value != 32'd0);
            2'b10: w_flag = ~r_value[31];
            2'b11: w_flag = r_value[31];
            default: w_flag = 1'b0;
        endcase
    end

    assign w_target = r_pc + {{13{r_c[18]}}, r_c};

    // ------------------------------------------------------------------
    // output logic: next values are decoded from the upcoming state so
    // every output leaves a flop and aligns with the state it describes
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt    = (w_state_nxt != c_IDLE);
        w_rd_req_nxt  = (w_state_nxt == c_READ);
        w_done_nxt    = (w_state_nxt == c_COMMIT);
        w_err_nxt     = w_accept && !w_op_ok;
        w_pc_load_nxt = (r_state == c_EVAL) && w_flag;
        w_taken_nxt   = r_taken;
        w_pc_next_nxt = r_pc_next;
        if (w_accept) begin
            w_taken_nxt = 1'b0;
        end
        if (r_state == c_EVAL) begin
            w_taken_nxt   = w_flag;
            w_pc_next_nxt = w_target;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_busy    <= 1'b0;
            r_rd_req  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_taken   <= 1'b0;
            r_pc_load <= 1'b0;
            r_pc_next <= 32'd0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_rd_req  <= w_rd_req_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_taken   <= w_taken_nxt;
            r_pc_load <= w_pc_load_nxt;
            r_pc_next <= w_pc_next_nxt;
        end
    end

    // ------------------------------------------------------------------
    // instruction / operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_c2     <= 2'd0;
            r_c      <= 19'd0;
            r_pc     <= 32'd0;
            r_ra_sel <= 4'd0;
            r_value  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_c2     <= bus.ir[20:19];
                r_c      <= bus.ir[18:0];
                r_pc     <= bus.pc_in;
                r_ra_sel <= bus.ir[26:23];
            end
            if ((r_state == c_READ) && bus.rd_ack) begin
                r_value <= bus.reg_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // branch statistics
    // ------------------------------------------------------------------
`ifdef BRANCH_STATS_EN
    logic [15:0] r_taken_cnt;
    logic [15:0] r_nottaken_cnt;

    // r_taken already holds this branch's flag while in COMMIT
    always_ff @(posedge clk) begin
        if (clr) begin
            r_taken_cnt    <= 16'd0;
            r_nottaken_cnt <= 16'd0;
        end else if (r_state == c_COMMIT) begin
            if (r_taken) begin
                if (r_taken_cnt != 16'hFFFF) r_taken_cnt <= r_taken_cnt + 16'd1;
            end else begin
                if (r_nottaken_cnt != 16'hFFFF) r_nottaken_cnt <= r_nottaken_cnt + 16'd1;
            end
        end
    end

    assign bus.taken_cnt    = r_taken_cnt;
    assign bus.nottaken_cnt = r_nottaken_cnt;
`else
    assign bus.taken_cnt    = 16'd0;
    assign bus.nottaken_cnt = 16'd0;
`endif

    assign bus.busy    = r_busy;
    assign bus.rd_req  = r_rd_req;
    assign bus.ra_sel  = r_ra_sel;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.taken   = r_taken;
    assign bus.pc_load = r_pc_load;
    assign bus.pc_next = r_pc_next;

endmodule

`default_nettype wire

// File: tb/tb_branch_sequencer.sv
// ============================================================================
//  Module      : tb_branch_sequencer
//  Description : Directed scoreboard bench for branch_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_sequencer;

    localparam logic [4:0] c_BR  = 5'b10010;
    localparam logic [4:0] c_BAD = 5'b00011;
`ifdef BRANCH_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    typedef struct {
        bit          is_err;
        int          cyc;
        bit          taken;
        bit          pc_load;
        logic [31:0] pc_next;
    } exp_t;

    logic clk;
    logic clr;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    exp_t q[$];

    // read responder controls
    int          ack_delay;
    logic [31:0] ack_value;
    logic [3:0]  exp_ra;
    bit          ack_auto;
    logic        manual_ack;
    int          wcnt;

    branch_sequencer_if bus ();

    branch_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [1:0] c2, input logic [18:0] c);
        return {op, ra, 2'b00, c2, c};
    endfunction

    // monitor: pop and compare whenever the DUT reports completion or error
    always @(negedge clk) begin
        exp_t e;
        if (!clr && (bus.done || bus.err)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: done=%b err=%b with empty scoreboard (cycle %0d)",
                         bus.done, bus.err, cyc);
            end else begin
                e = q.pop_front();
                check("kind_err", {31'd0, bus.err}, {31'd0, e.is_err});
                check("latency", cyc, e.cyc);
                if (!e.is_err) begin
                    check("taken", {31'd0, bus.taken}, {31'd0, e.taken});
                    check("pc_load", {31'd0, bus.pc_load}, {31'd0, e.pc_load});
                    check("pc_next", bus.pc_next, e.pc_next);
                end
            end
        end else if (bus.pc_load) begin
            n_cmp++;
            n_fail++;
            $display("FAIL stray_pc_load: pc_load=1 without done (cycle %0d)", cyc);
        end
    end

    // register-file responder; ra_sel must match the latched Ra in every read cycle
    always @(negedge clk) begin
        if (!ack_auto) begin
            bus.rd_ack = manual_ack;
            wcnt = 0;
        end else if (bus.rd_req && !clr) begin
            check("ra_sel", {28'd0, bus.ra_sel}, {28'd0, exp_ra});
            if (wcnt == ack_delay) begin
                bus.rd_ack   = 1'b1;
                bus.reg_data = ack_value;
                wcnt = 0;
            end else begin
                bus.rd_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.rd_ack = 1'b0;
            wcnt = 0;
        end
    end

    // drive start for one cycle at a negedge and record the expected response
    task automatic issue(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] v,
                         input int dly, input bit is_err, input bit et, input logic [31:0] ep);
        exp_t e;
        ack_value    = v;
        ack_delay    = dly;
        exp_ra       = ir[26:23];
        bus.start    = 1'b1;
        bus.ir       = ir;
        bus.pc_in    = pc;
        e.is_err     = is_err;
        e.cyc        = is_err ? cyc + 1 : cyc + 3 + dly;
        e.taken      = et;
        e.pc_load    = et;
        e.pc_next    = ep;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy || q.size() != 0) && n < 40);
        if (n >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%b pending=%0d after %0d cycles", bus.busy, q.size(), n);
            q.delete();
        end
    endtask

    task automatic run_br(input logic [1:0] c2, input logic [3:0] ra, input logic [31:0] v,
                          input logic [18:0] c, input logic [31:0] pc, input int dly,
                          input bit et, input logic [31:0] ep);
        issue(mk_ir(c_BR, ra, c2, c), pc, v, dly, 1'b0, et, ep);
        wait_idle();
        check("taken_held", {31'd0, bus.taken}, {31'd0, et});
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_fail = 0;
        ack_delay = 0; ack_value = 32'd0; exp_ra = 4'd0;
        ack_auto = 1'b1; manual_ack = 1'b0; wcnt = 0;
        clr = 1'b1;
        bus.start = 1'b0; bus.ir = 32'd0; bus.pc_in = 32'd0;
        bus.rd_ack = 1'b0; bus.reg_data = 32'd0;
        repeat (3) @(negedge clk);

        check("rst_rd_req",  {31'd0, bus.rd_req},  32'd0);
        check("rst_ra_sel",  {28'd0, bus.ra_sel},  32'd0);
        check("rst_busy",    {31'd0, bus.busy},    32'd0);
        check("rst_done",    {31'd0, bus.done},    32'd0);
        check("rst_err",     {31'd0, bus.err},     32'd0);
        check("rst_taken",   {31'd0, bus.taken},   32'd0);
        check("rst_pc_load", {31'd0, bus.pc_load}, 32'd0);
        check("rst_pc_next", bus.pc_next,          32'd0);
        check("rst_tcnt",    {16'd0, bus.taken_cnt},    32'd0);
        check("rst_ntcnt",   {16'd0, bus.nottaken_cnt}, 32'd0);
        clr = 1'b0;
        @(negedge clk);

        // c2, Ra, value, C, pc_in, ack delay, expected taken, expected target
        run_br(2'b00, 4'd5, 32'd0,         19'h00010, 32'h0000_0100, 0, 1'b1, 32'h0000_0110);
        run_br(2'b01, 4'd2, 32'd0,         19'h7FFFC, 32'h0000_0100, 0, 1'b0, 32'h0000_00FC);
        run_br(2'b10, 4'd3, 32'h8000_0000, 19'h00020, 32'h0000_0200, 0, 1'b0, 32'h0000_0220);
        run_br(2'b11, 4'd4, 32'h8000_0000, 19'h00001, 32'h0000_0300, 1, 1'b1, 32'h0000_0301);
        run_br(2'b10, 4'd6, 32'd0,         19'h40000, 32'h0000_0010, 0, 1'b1, 32'hFFFC_0010);

        check("stats_taken",    {16'd0, bus.taken_cnt},    c_STATS ? 32'd3 : 32'd0);
        check("stats_nottaken", {16'd0, bus.nottaken_cnt}, c_STATS ? 32'd2 : 32'd0);

        // 3-cycle ack delay; stray starts (bad opcode, other Ra) held through COMMIT
        issue(mk_ir(c_BR, 4'd9, 2'b01, 19'h3FFFF), 32'hFFFF_FFF0, 32'd5, 3, 1'b0, 1'b1, 32'h0003_FFEF);
        bus.start = 1'b1;
        bus.ir    = mk_ir(c_BAD, 4'd15, 2'b00, 19'h0);
        bus.pc_in = 32'hDEAD_0000;
        repeat (6) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        check("taken_after_delay", {31'd0, bus.taken}, 32'd1);
        check("pc_next_held", bus.pc_next, 32'h0003_FFEF);

        run_br(2'b00, 4'd7, 32'd1, 19'h00000, 32'h0000_0500, 0, 1'b0, 32'h0000_0500);

        // bad opcode: err pulse, no read
        issue(mk_ir(c_BAD, 4'd1, 2'b00, 19'h10), 32'h0000_0700, 32'd0, 0, 1'b1, 1'b0, 32'd0);
        check("err_no_req0", {31'd0, bus.rd_req}, 32'd0);
        check("err_not_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("err_no_req1", {31'd0, bus.rd_req}, 32'd0);
        wait_idle();

        // bad opcode followed by a valid start in the err cycle itself
        issue(mk_ir(c_BAD, 4'd1, 2'b00, 19'h10), 32'h0000_0700, 32'd0, 0, 1'b1, 1'b0, 32'd0);
        issue(mk_ir(c_BR, 4'd8, 2'b11, 19'h00004), 32'h0000_0800, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 32'h0000_0804);
        wait_idle();

        // clr during READ with an ack presented on the same edge
        ack_auto = 1'b0;
        manual_ack = 1'b0;
        exp_ra = 4'd10;
        bus.start = 1'b1;
        bus.ir    = mk_ir(c_BR, 4'd10, 2'b00, 19'h00008);
        bus.pc_in = 32'h0000_0900;
        bus.reg_data = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("clr_pre_req", {31'd0, bus.rd_req}, 32'd1);
        @(negedge clk);
        manual_ack = 1'b1;
        bus.rd_ack = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_req_drop", {31'd0, bus.rd_req}, 32'd0);
        check("clr_busy",     {31'd0, bus.busy},   32'd0);
        check("clr_done",     {31'd0, bus.done},   32'd0);
        check("clr_pc_load",  {31'd0, bus.pc_load}, 32'd0);
        @(negedge clk);
        manual_ack = 1'b0;
        bus.rd_ack = 1'b0;
        check("clr_ack_ignored", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("clr_still_idle", {31'd0, bus.busy}, 32'd0);
        check("clr_tcnt", {16'd0, bus.taken_cnt}, 32'd0);
        ack_auto = 1'b1;

`ifdef BRANCH_STATS_EN
        force dut.r_taken_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_taken_cnt;
        run_br(2'b00, 4'd5, 32'd0, 19'h00010, 32'h0000_0100, 0, 1'b1, 32'h0000_0110);
        check("stats_saturate", {16'd0, bus.taken_cnt}, 32'h0000_FFFF);
        check("stats_nt_after_sat", {16'd0, bus.nottaken_cnt}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
